// File: rtl/anita3_buffer_manager.sv
`timescale 1ns / 1ps
// ANITA-3 digitizer hold-buffer allocator.
// Assigns buffers to triggers, drives the digitize strobe and keeps housekeeping counters.
module anita3_buffer_manager #(
    parameter int DIGITIZE_CYCLES = 8,
    parameter int GAP_CYCLES      = 4,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk125_i,
    input  logic                   rst_i,
    input  logic                   trig_i,
    input  logic [3:0]             trig_source_i,
    input  logic                   clear_i,
    input  logic [1:0]             clear_buffer_i,
    input  logic                   clear_all_i,
    input  logic                   count_reset_i,
    output logic                   digitize_o,
    output logic [1:0]             digitize_buffer_o,
    output logic [3:0]             digitize_source_o,
    output logic [3:0]             buffer_status_o,
    output logic                   busy_o,
    output logic                   full_o,
    output logic [COUNT_WIDTH-1:0] dead_count_o,
    output logic [COUNT_WIDTH-1:0] drop_count_o
);

    localparam int MAX_CYCLES = (DIGITIZE_CYCLES > GAP_CYCLES) ?
                                DIGITIZE_CYCLES : GAP_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DIGITIZE,
        GAP
    } state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [3:0]     held;
    logic [1:0]     next_ptr;
    logic [1:0]     sel;
    logic [1:0]     cand;
    logic           found;
    logic           accept;
    logic           drop;
    logic [3:0]     clr_mask;
    logic [3:0]     set_mask;

    assign full_o          = &held;
    assign busy_o          = (state != IDLE);
    assign buffer_status_o = held;

    // A trigger is taken only from IDLE with a free buffer and no abort pending.
    assign accept = (state == IDLE) && trig_i && !full_o && !clear_all_i;
    assign drop   = trig_i && !accept;

    assign clr_mask = clear_i ? (4'b0001 << clear_buffer_i) : 4'b0000;
    assign set_mask = accept ? (4'b0001 << sel) : 4'b0000;

    // Round-robin search for the first free buffer starting at next_ptr.
    always_comb begin
        sel   = next_ptr;
        cand  = next_ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = next_ptr + 2'(i);
            if (!found && !held[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Strobe sequencer: fixed-width digitize pulse followed by a fixed gap.
    always_ff @(posedge clk125_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            timer             <= '0;
            digitize_o        <= 1'b0;
            digitize_buffer_o <= 2'd0;
            digitize_source_o <= 4'd0;
        end else if (clear_all_i) begin
            state      <= IDLE;
            timer      <= '0;
            digitize_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    timer <= '0;
                    if (accept) begin
                        state             <= DIGITIZE;
                        digitize_o        <= 1'b1;
                        digitize_buffer_o <= sel;
                        digitize_source_o <= trig_source_i;
                    end
                end
                DIGITIZE: begin
                    if (timer == TW'(DIGITIZE_CYCLES - 1)) begin
                        state      <= GAP;
                        timer      <= '0;
                        digitize_o <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    if (timer == TW'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    timer      <= '0;
                    digitize_o <= 1'b0;
                end
            endcase
        end
    end

    // Hold map: releases apply before the new allocation so both land together.
    always_ff @(posedge clk125_i or posedge rst_i) begin
        if (rst_i) begin
            held     <= 4'b0000;
            next_ptr <= 2'd0;
        end else if (clear_all_i) begin
            held     <= 4'b0000;
            next_ptr <= 2'd0;
        end else begin
            held <= (held & ~clr_mask) | set_mask;
            if (accept) begin
                next_ptr <= sel + 2'd1;
            end
        end
    end

    // Saturating deadtime and dropped-trigger counters.
    always_ff @(posedge clk125_i or posedge rst_i) begin
        if (rst_i) begin
            dead_count_o <= '0;
            drop_count_o <= '0;
        end else if (count_reset_i) begin
            dead_count_o <= '0;
            drop_count_o <= '0;
        end else begin
            if (full_o && (dead_count_o != '1)) begin
                dead_count_o <= dead_count_o + 1'b1;
            end
            if (drop && (drop_count_o != '1)) begin
                drop_count_o <= drop_count_o + 1'b1;
            end
        end
    end

endmodule
